// File: rtl/bundler.sv
// Hyperdimensional bundler: per-dimension majority vote over NUM_HVS captured
// hypervectors, evaluated PAR_BITS dimensions per clock.
module bundler #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 6,
  parameter int PAR_BITS   = 2
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                en,
  input  logic [NUM_HVS-1:0][DIMENSIONS-1:0]  hv_array,
  output logic                                out,
  output logic [DIMENSIONS-1:0]               hv_out
);

  localparam int NCH   = (DIMENSIONS + PAR_BITS - 1) / PAR_BITS;
  localparam int PAD_W = NCH * PAR_BITS;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(NUM_HVS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   chunk_q, chunk_d;
  logic [NUM_HVS-1:0][PAD_W-1:0]   cap_q, cap_d;
  logic [PAD_W-1:0]                res_q, res_d;
  logic [DIMENSIONS-1:0]           hv_out_q, hv_out_d;
  logic                            out_q, out_d;

  logic [PAR_BITS-1:0]             lanes;
  logic [CNT_W-1:0]                cnt;
  logic [CNT_W:0]                  twice_cnt;

  // The captured vectors shift down one chunk per cycle, so the current chunk
  // always sits in the low PAR_BITS lanes; padding lanes vote on zeros.
  always_comb begin
    lanes     = '0;
    cnt       = '0;
    twice_cnt = '0;
    for (int j = 0; j < PAR_BITS; j++) begin
      cnt = '0;
      for (int i = 0; i < NUM_HVS; i++) begin
        cnt = cnt + CNT_W'(cap_q[i][j]);
      end
      twice_cnt = {cnt, 1'b0};
      if (twice_cnt > (CNT_W+1)'(NUM_HVS)) begin
        lanes[j] = 1'b1;
      end else if (twice_cnt == (CNT_W+1)'(NUM_HVS)) begin
        lanes[j] = cap_q[0][j];
      end else begin
        lanes[j] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    cap_d    = cap_q;
    res_d    = res_q;
    hv_out_d = hv_out_q;
    out_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          for (int i = 0; i < NUM_HVS; i++) begin
            cap_d[i] = PAD_W'(hv_array[i]);
          end
          chunk_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < NUM_HVS; i++) begin
          cap_d[i] = cap_q[i] >> PAR_BITS;
        end
        // New chunk enters at the top; after NCH shifts chunk 0 lands at bit 0.
        res_d   = (res_q >> PAR_BITS) | (PAD_W'(lanes) << (PAD_W - PAR_BITS));
        chunk_d = chunk_q + CW'(1);
        if (chunk_q == CW'(NCH - 1)) begin
          hv_out_d = res_d[DIMENSIONS-1:0];
          out_d    = 1'b1;
          chunk_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      chunk_q  <= '0;
      cap_q    <= '0;
      res_q    <= '0;
      hv_out_q <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      cap_q    <= cap_d;
      res_q    <= res_d;
      hv_out_q <= hv_out_d;
      out_q    <= out_d;
    end
  end

  assign out    = out_q;
  assign hv_out = hv_out_q;

endmodule

// File: tb/tb_bundler.sv
// Bench for bundler: three small configurations checked every cycle against a
// behavioural majority/latency model, plus literal results for known vector sets.
module tb_bundler;

  localparam int D = 6;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic                en = 1'b0;
  logic [5:0][D-1:0]   hv_array = '0;
  logic [2:0]          out_w;
  logic [D-1:0]        hv_w [3];

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  bundler #(.DIMENSIONS(D), .NUM_HVS(6), .PAR_BITS(2)) dut_a (
    .clk(clk), .nrst(nrst), .en(en), .hv_array(hv_array),
    .out(out_w[0]), .hv_out(hv_w[0]));

  bundler #(.DIMENSIONS(D), .NUM_HVS(6), .PAR_BITS(4)) dut_b (
    .clk(clk), .nrst(nrst), .en(en), .hv_array(hv_array),
    .out(out_w[1]), .hv_out(hv_w[1]));

  bundler #(.DIMENSIONS(D), .NUM_HVS(5), .PAR_BITS(2)) dut_c (
    .clk(clk), .nrst(nrst), .en(en), .hv_array(hv_array[4:0]),
    .out(out_w[2]), .hv_out(hv_w[2]));

  int           nhv [3] = '{6, 6, 5};
  int           nch [3] = '{3, 2, 3};
  bit           m_busy [3];
  int           m_left [3];
  logic [D-1:0] m_res [3];
  logic         m_out [3];
  logic [D-1:0] m_hv [3];

  function automatic logic [D-1:0] majority(input logic [5:0][D-1:0] v, input int n);
    logic [D-1:0] r;
    int c;
    r = '0;
    for (int d = 0; d < D; d++) begin
      c = 0;
      for (int i = 0; i < n; i++) c += int'(v[i][d]);
      if (2 * c > n)      r[d] = 1'b1;
      else if (2 * c < n) r[d] = 1'b0;
      else                r[d] = v[0][d];
    end
    return r;
  endfunction

  // Model: result is fixed at the capture edge, published nch edges later.
  always @(posedge clk or negedge nrst) begin
    for (int k = 0; k < 3; k++) begin
      if (!nrst) begin
        m_busy[k] = 1'b0;
        m_left[k] = 0;
        m_res[k]  = '0;
        m_out[k]  = 1'b0;
        m_hv[k]   = '0;
      end else begin
        m_out[k] = 1'b0;
        if (m_busy[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 1'b0;
            m_out[k]  = 1'b1;
            m_hv[k]   = m_res[k];
          end
        end else if (en) begin
          m_busy[k] = 1'b1;
          m_left[k] = nch[k];
          m_res[k]  = majority(hv_array, nhv[k]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_on) begin
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("out[%0d]", k), 32'(out_w[k]), 32'(m_out[k]));
          checkOutput($sformatf("hv_out[%0d]", k), 32'(hv_w[k]), 32'(m_hv[k]));
        end
      end
    end
  end

  task automatic randomize_hv();
    for (int i = 0; i < 6; i++) hv_array[i] = 6'($urandom);
  endtask

  task automatic applyStimulus(input logic [5:0][D-1:0] v);
    int lat_a;
    int lat_b;
    @(negedge clk);
    hv_array = v;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    randomize_hv();
    lat_a = 0;
    lat_b = 0;
    for (int i = 1; i <= 20 && (lat_a == 0 || lat_b == 0); i++) begin
      @(posedge clk);
      #1;
      if (out_w[0] && lat_a == 0) lat_a = i;
      if (out_w[1] && lat_b == 0) lat_b = i;
      randomize_hv();
    end
    checkOutput("latency_a", 32'(lat_a), 32'd3);
    checkOutput("latency_b", 32'(lat_b), 32'd2);
    repeat (3) @(negedge clk);
  endtask

  logic [5:0][D-1:0] set1;
  logic [5:0][D-1:0] set2;
  logic [5:0][D-1:0] set3;
  int cnt_a;
  int cnt_b;

  initial begin
    set1 = {6'b111011, 6'b100011, 6'b100011, 6'b001111, 6'b000111, 6'b001101};
    set2 = {6'b010000, 6'b000100, 6'b010100, 6'b001000, 6'b010000, 6'b000010};
    set3 = {6'b111110, 6'b110101, 6'b010111, 6'b001111, 6'b011011, 6'b111011};

    // With five voters bit 3 of set1 only gets 2 votes, so it drops to 0.
    checkOutput("model_set1_n6", 32'(majority(set1, 6)), 32'b001111);
    checkOutput("model_set1_n5", 32'(majority(set1, 5)), 32'b000111);
    checkOutput("model_set2_n6", 32'(majority(set2, 6)), 32'b000000);
    checkOutput("model_set3_n6", 32'(majority(set3, 6)), 32'b111111);

    cmp_on = 1'b1;
    nrst = 1'b0;
    en = 1'b1;
    repeat (4) begin
      randomize_hv();
      @(negedge clk);
    end
    checkOutput("rst_out", 32'(out_w), 32'd0);
    checkOutput("rst_hv", 32'(hv_w[0]), 32'd0);
    nrst = 1'b1;
    en = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus(set1);
    checkOutput("set1_a", 32'(hv_w[0]), 32'b001111);
    checkOutput("set1_b", 32'(hv_w[1]), 32'b001111);
    checkOutput("set1_c", 32'(hv_w[2]), 32'b000111);
    applyStimulus(set2);
    checkOutput("set2_a", 32'(hv_w[0]), 32'b000000);
    applyStimulus(set3);
    checkOutput("set3_a", 32'(hv_w[0]), 32'b111111);
    checkOutput("set3_b", 32'(hv_w[1]), 32'b111111);

    @(negedge clk);
    en = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      cnt_a += int'(out_w[0]);
      cnt_b += int'(out_w[1]);
      randomize_hv();
    end
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pulses_a", 32'(cnt_a), 32'd10);
    checkOutput("pulses_b", 32'(cnt_b), 32'd13);

    @(negedge clk);
    hv_array = set3;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    hv_array = set1;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checkOutput("rst_mid_out", 32'(out_w), 32'd0);
    checkOutput("rst_mid_hv_a", 32'(hv_w[0]), 32'd0);
    checkOutput("rst_mid_hv_b", 32'(hv_w[1]), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(set1);
    checkOutput("restart_a", 32'(hv_w[0]), 32'b001111);
    checkOutput("restart_c", 32'(hv_w[2]), 32'b000111);

    repeat (300) begin
      @(negedge clk);
      en = (($urandom % 3) == 0);
      randomize_hv();
    end
    @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
